// File: rtl/change_dispenser.sv
// ============================================================================
// change_dispenser
// ----------------------------------------------------------------------------
// Pays change back to the customer. A change amount from the vending
// controller is broken into coins greedily (largest denomination first).
// The coin ejector is driven one coin at a time with an eject/ack handshake.
// Completion is reported with a done pulse. A mechanism timeout, or having no
// usable denomination left, is reported with an error pulse.
//
// Optional feature (compile-time macro CHANGE_INVENTORY_EN):
//   Adds the coin_empty[3:0] input. A set bit marks that denomination as out
//   of stock, and the selector skips it. When the macro is undefined, every
//   denomination is treated as available and the port does not exist.
//
// Parameters:
//   CURRENCY_WIDTH  width of change_amount / remaining
//   DENOM_0..3      coin values for coin_sel 0..3 (0 largest, 3 must be 1)
//   ACK_TIMEOUT     cycles in EJECT without an ack before error (1..255)
//
// Ports:
//   clk            system clock, rising edge
//   rstn           asynchronous active-low reset
//   change_amount  amount to pay, sampled together with change_start
//   change_start   single-cycle request, honoured only in IDLE
//   busy           high from the cycle after a non-zero start until DONE/ERROR exits
//   coin_sel       denomination index of the coin being ejected
//   coin_eject     eject request, held until ack or timeout
//   coin_ack       asynchronous level from the mechanism; rising edge = coin dropped
//   remaining      amount still unpaid
//   change_done    one-cycle pulse on successful completion
//   change_error   one-cycle pulse on timeout or when change cannot be made
//   coin_empty     (CHANGE_INVENTORY_EN only) per-denomination out-of-stock flags
// ============================================================================
module change_dispenser #(
    parameter int CURRENCY_WIDTH = 7,
    parameter int DENOM_0        = 10,
    parameter int DENOM_1        = 5,
    parameter int DENOM_2        = 2,
    parameter int DENOM_3        = 1,
    parameter int ACK_TIMEOUT    = 200
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [CURRENCY_WIDTH-1:0] change_amount,
    input  logic                      change_start,
    output logic                      busy,
    output logic [1:0]                coin_sel,
    output logic                      coin_eject,
    input  logic                      coin_ack,
`ifdef CHANGE_INVENTORY_EN
    input  logic [3:0]                coin_empty,
`endif
    output logic [CURRENCY_WIDTH-1:0] remaining,
    output logic                      change_done,
    output logic                      change_error
);

    localparam int CW = CURRENCY_WIDTH;

    // Timeout fires on the last counted cycle so that coin_eject is high for
    // exactly ACK_TIMEOUT cycles when no ack ever arrives.
    localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        EJECT  = 3'd2,
        DONE   = 3'd3,
        ERROR  = 3'd4
    } state_t;

    state_t state_reg;
    state_t state_next;

    // ------------------------------------------------------------------------
    // Registered datapath
    // ------------------------------------------------------------------------
    logic [CW-1:0] remaining_reg;
    logic [1:0]    coin_sel_reg;
    logic          coin_eject_reg;
    logic          busy_reg;
    logic [7:0]    cnt_reg;
    logic          ack_s0_reg;
    logic          ack_s1_reg;

    // ------------------------------------------------------------------------
    // Denomination table and coin selection
    // ------------------------------------------------------------------------
    logic [CW-1:0] denom [4];
    logic [3:0]    avail;
    logic [3:0]    fits;
    logic [3:0]    eligible;
    logic [1:0]    sel_idx;
    logic          sel_found;

    assign denom[0] = CW'(DENOM_0);
    assign denom[1] = CW'(DENOM_1);
    assign denom[2] = CW'(DENOM_2);
    assign denom[3] = CW'(DENOM_3);

`ifdef CHANGE_INVENTORY_EN
    assign avail = ~coin_empty;
`else
    assign avail = 4'b1111;
`endif

    // A denomination is a candidate when it does not exceed what is still
    // owed and the mechanism has coins of that value.
    for (genvar gi = 0; gi < 4; gi++) begin : g_eligible
        assign fits[gi]     = (denom[gi] <= remaining_reg);
        assign eligible[gi] = fits[gi] & avail[gi];
    end

    // Smallest eligible index wins, i.e. the largest coin that still fits.
    // The loop runs downward so the lowest set bit overrides the others.
    always_comb begin
        sel_idx   = 2'd0;
        sel_found = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (eligible[i]) begin
                sel_idx   = 2'(i);
                sel_found = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Ack edge detection and per-coin bookkeeping
    // ------------------------------------------------------------------------
    logic          ack_edge;
    logic          timeout_hit;
    logic [CW-1:0] remaining_after;

    // The edge is taken after the first synchronizer stage. A held ack stays
    // in both flops and therefore produces only one edge.
    assign ack_edge    = ack_s0_reg & ~ack_s1_reg;
    assign timeout_hit = (cnt_reg == TIMEOUT_LAST);

    // Cannot underflow: coin_sel_reg was chosen with denom <= remaining.
    assign remaining_after = remaining_reg - denom[coin_sel_reg];

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (change_start) begin
                    if (change_amount != '0) begin
                        state_next = SELECT;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            SELECT: begin
                // Without inventory tracking a 1-unit coin always fits, so
                // the ERROR branch is only reachable with stock exhausted.
                state_next = sel_found ? EJECT : ERROR;
            end
            EJECT: begin
                // A coin that lands on the timeout cycle still counts.
                if (ack_edge) begin
                    state_next = (remaining_after == '0) ? DONE : SELECT;
                end else if (timeout_hit) begin
                    state_next = ERROR;
                end
            end
            DONE:    state_next = IDLE;
            ERROR:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output logic (status pulses are pure functions of state)
    // ------------------------------------------------------------------------
    always_comb begin
        change_done  = 1'b0;
        change_error = 1'b0;
        case (state_reg)
            DONE:    change_done  = 1'b1;
            ERROR:   change_error = 1'b1;
            default: begin
                change_done  = 1'b0;
                change_error = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Ack synchronizer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ack_s0_reg <= 1'b0;
            ack_s1_reg <= 1'b0;
        end else begin
            ack_s0_reg <= coin_ack;
            ack_s1_reg <= ack_s0_reg;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers driven by the current state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            remaining_reg  <= '0;
            coin_sel_reg   <= 2'd0;
            coin_eject_reg <= 1'b0;
            busy_reg       <= 1'b0;
            cnt_reg        <= 8'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // A zero request loads 0 and goes straight to DONE; busy
                    // is only raised when there is something to pay out.
                    if (change_start) begin
                        remaining_reg <= change_amount;
                        busy_reg      <= (change_amount != '0);
                    end
                end
                SELECT: begin
                    if (sel_found) begin
                        coin_sel_reg   <= sel_idx;
                        coin_eject_reg <= 1'b1;
                        cnt_reg        <= 8'd0;
                    end
                end
                EJECT: begin
                    cnt_reg <= cnt_reg + 8'd1;
                    if (ack_edge) begin
                        coin_eject_reg <= 1'b0;
                        remaining_reg  <= remaining_after;
                    end else if (timeout_hit) begin
                        // remaining keeps the unpaid value for the controller.
                        coin_eject_reg <= 1'b0;
                    end
                end
                DONE: begin
                    busy_reg <= 1'b0;
                end
                ERROR: begin
                    busy_reg <= 1'b0;
                end
                default: begin
                    busy_reg       <= 1'b0;
                    coin_eject_reg <= 1'b0;
                end
            endcase
        end
    end

    assign remaining  = remaining_reg;
    assign coin_sel   = coin_sel_reg;
    assign coin_eject = coin_eject_reg;
    assign busy       = busy_reg;

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Pays change back to the customer. It is the outbound counterpart of the coin-accepting currency accumulator.
- Takes a change amount from the vending controller and breaks it into coins greedily (largest denomination first).
- Drives the coin ejector mechanism one coin at a time using an eject/ack handshake. The ack comes from the mechanism asynchronously.
- Reports done, or error on mechanism timeout.

Parameters:
- CURRENCY_WIDTH, 7, width of change_amount and remaining.
- DENOM_0, 10, value of coin_sel=0 (largest).
- DENOM_1, 5, value of coin_sel=1.
- DENOM_2, 2, value of coin_sel=2.
- DENOM_3, 1, value of coin_sel=3 (smallest; must be 1).
- ACK_TIMEOUT, 200, cycles in EJECT without an ack before error (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- change_amount  in  CURRENCY_WIDTH  amount to pay; sampled on change_start.
- change_start  in  1  synchronous single-cycle request.
- busy  out  1  high from the cycle after an accepted start until DONE/ERROR exits.
- coin_sel  out  2  denomination index of the current coin.
- coin_eject  out  1  eject request; held high until ack or timeout.
- coin_ack  in  1  async level from the mechanism; a rising edge means the coin was dropped.
- remaining  out  CURRENCY_WIDTH  amount still unpaid.
- change_done  out  1  one-cycle pulse on successful completion.
- change_error  out  1  one-cycle pulse on timeout or when change cannot be made.

Behaviour:
- Reset values (async, all outputs): busy=0, coin_sel=0, coin_eject=0, remaining=0, change_done=0, change_error=0, state=IDLE, sync flops=0, timeout counter=0.
- Reset mid-operation aborts immediately. The coin in flight is not counted.
- coin_ack path:
  - Two-flop synchronizer (s0, s1).
  - ack_edge = s0 & ~s1.
  - Edge latency: 2 clk from ack assertion.
  - An ack held high counts once. Edges outside EJECT are ignored.
- States: IDLE, SELECT, EJECT, DONE, ERROR.
- IDLE:
  - change_start with change_amount != 0: remaining <= change_amount, go to SELECT.
  - change_start with change_amount == 0: go to DONE, no eject.
- SELECT (1 cycle):
  - coin_sel <= smallest index whose DENOM <= remaining.
  - coin_eject <= 1, counter <= 0, go to EJECT.
- EJECT:
  - Counter increments each cycle.
  - On ack_edge: coin_eject <= 0, remaining <= remaining - DENOM[coin_sel]. Go to DONE if the result is 0, else SELECT.
  - ack_edge wins over a timeout in the same cycle.
  - If the counter reaches ACK_TIMEOUT: coin_eject <= 0, go to ERROR. remaining keeps the unpaid value.
- DONE: change_done=1 for one cycle, busy <= 0, go to IDLE.
- ERROR: change_error=1 for one cycle, busy <= 0, go to IDLE. remaining holds until the next accepted start.
- change_start while busy (any state other than IDLE) is ignored.
- Subtraction never underflows, because the selected DENOM <= remaining.
- Cycles per coin: 1 (SELECT) + ack wait + 2 (sync) + 1.

Optional Feature:
- Macro: CHANGE_INVENTORY_EN.
- When defined:
  - Adds input port coin_empty[3:0]. Bit i high means denomination i is out of stock.
  - coin_empty is sampled synchronously in SELECT.
  - SELECT picks the smallest index i with coin_empty[i]=0 and DENOM_i <= remaining.
  - If no such index exists: go to ERROR with coin_eject=0; remaining holds the unpaid value.
- When undefined: no port; all denominations are treated as available.

Test Plan:
- Greedy change: start with amount=18, ack each eject 5 cycles later.
  - coin_sel sequence 0,1,2,3.
  - remaining 8,3,1,0.
  - change_done pulses once; busy falls; coin_error never asserts.
- Zero amount: start with amount=0 → change_done 1 cycle later, coin_eject never high, busy never high.
- Timeout: ACK_TIMEOUT=16, amount=7, no ack.
  - coin_eject high for exactly 16 cycles, coin_sel=1.
  - change_error pulses once; remaining=7.
- Held ack / busy start: amount=4, ack held high for 50 cycles.
  - Only one coin counted per rising edge; remaining 2 after the first edge.
  - A second change_start mid-transaction is ignored.
- Reset mid-EJECT: assert rstn=0 with coin_eject high → all outputs at reset values immediately. A later start with amount=1 completes normally.
- Inventory (CHANGE_INVENTORY_EN): coin_empty=4'b0010, amount=8.
  - coin_sel 2,2,2,2; change_done pulses.
  - Then coin_empty=4'b1111, amount=3 → change_error, no eject, remaining=3.
